// File: rtl/mode_select_controller.sv
// mode_select_controller: debounced push-button / auto-step sequencer for the four-state timing mode
module mode_select_controller #(
  parameter int DEBOUNCE_COUNT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       debounce_tick,
  input  logic       slow_tick,
  input  logic       button,
  input  logic       auto_en,
  output logic [1:0] state,
  output logic       state_change,
  output logic       first_pass,
  output logic       button_level
);
  logic       sync1;
  logic       btn_s;
  logic       dbt_prev;
  logic       slt_prev;
  logic       lvl_prev;
  logic [3:0] cnt;
  logic       dbs;
  logic       sls;
  logic       press;
  logic       advance;
  assign dbs     = debounce_tick & ~dbt_prev;
  assign sls     = slow_tick & ~slt_prev;
  assign press   = button_level & ~lvl_prev;
  assign advance = press | (auto_en & sls);
  // button synchroniser and tick history; history resets high so ticks already high at release do not strobe
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1    <= 1'b0;
      btn_s    <= 1'b0;
      dbt_prev <= 1'b1;
      slt_prev <= 1'b1;
    end else begin
      sync1    <= button;
      btn_s    <= sync1;
      dbt_prev <= debounce_tick;
      slt_prev <= slow_tick;
    end
  end
  // debounce: level toggles only after DEBOUNCE_COUNT consecutive disagreeing strobes
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt          <= '0;
      button_level <= 1'b0;
      lvl_prev     <= 1'b0;
    end else begin
      lvl_prev <= button_level;
      if (dbs) begin
        if (btn_s == button_level) cnt <= '0;
        else if (cnt == 4'(DEBOUNCE_COUNT - 1)) begin
          button_level <= btn_s;
          cnt          <= '0;
        end else cnt <= cnt + 4'd1;
      end
    end
  end
  // mode counter: one step per press or enabled slow strobe, with change strobe and first-pass flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= 2'd0;
      state_change <= 1'b0;
      first_pass   <= 1'b1;
    end else begin
      state_change <= advance;
      if (advance) begin
        state      <= state + 2'd1;
        first_pass <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_mode_select_controller.sv
// tb_mode_select_controller: directed self-checking bench for mode_select_controller
module tb_mode_select_controller;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       debounce_tick = 1'b1;
  logic       slow_tick = 1'b1;
  logic       button = 1'b0;
  logic       auto_en = 1'b0;
  logic [1:0] state;
  logic       state_change;
  logic       first_pass;
  logic       button_level;
  int         total = 0;
  int         bad = 0;
  int         sc_cnt = 0;
  int         sc_base;
  logic [1:0] exp_seq [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
  mode_select_controller #(.DEBOUNCE_COUNT(4)) dut (
    .clk(clk), .rst_n(rst_n), .debounce_tick(debounce_tick), .slow_tick(slow_tick),
    .button(button), .auto_en(auto_en), .state(state), .state_change(state_change),
    .first_pass(first_pass), .button_level(button_level)
  );
  always #5 clk = ~clk;
  // count state_change pulses as seen at each rising edge
  always @(posedge clk) if (state_change === 1'b1) sc_cnt <= sc_cnt + 1;
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic dhigh();
    debounce_tick = 1'b1;
    step(1);
  endtask
  task automatic dlow();
    step(3);
    debounce_tick = 1'b0;
    step(4);
  endtask
  task automatic dpulse(input int n);
    repeat (n) begin
      dhigh();
      dlow();
    end
  endtask
  task automatic spulse();
    slow_tick = 1'b1;
    step(1);
  endtask
  task automatic sfinish();
    step(15);
    slow_tick = 1'b0;
    step(16);
  endtask
  initial begin
    logic quiet;
    step(2);
    rst_n = 1'b1;
    step(1);
    chk("reset_state", 32'(state), 0);
    chk("reset_first_pass", 32'(first_pass), 1);
    chk("reset_change", 32'(state_change), 0);
    chk("reset_level", 32'(button_level), 0);
    sc_base = sc_cnt;
    quiet = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (state !== 2'd0 || first_pass !== 1'b1 || state_change !== 1'b0) quiet = 1'b0;
      step(1);
    end
    chk("ticks_high_quiet", 32'(quiet), 1);
    chk("ticks_high_no_change", 32'(sc_cnt - sc_base), 0);
    debounce_tick = 1'b0;
    slow_tick = 1'b0;
    step(4);
    button = 1'b1;
    step(3);
    dpulse(3);
    chk("clean_level_before_4th", 32'(button_level), 0);
    dhigh();
    chk("clean_level_on_4th", 32'(button_level), 1);
    chk("clean_state_not_yet", 32'(state), 0);
    step(1);
    chk("clean_state", 32'(state), 1);
    chk("clean_change_pulse", 32'(state_change), 1);
    chk("clean_first_pass", 32'(first_pass), 0);
    step(1);
    chk("clean_change_single", 32'(state_change), 0);
    step(1);
    debounce_tick = 1'b0;
    step(4);
    dpulse(3);
    chk("held_one_advance", 32'(state), 1);
    button = 1'b0;
    step(3);
    dpulse(4);
    chk("release_level", 32'(button_level), 0);
    chk("release_no_advance", 32'(state), 1);
    sc_base = sc_cnt;
    button = 1'b1;
    step(3);
    dpulse(3);
    button = 1'b0;
    step(3);
    dpulse(1);
    button = 1'b1;
    step(3);
    dpulse(3);
    chk("bounce_level_held", 32'(button_level), 0);
    chk("bounce_state_held", 32'(state), 1);
    dhigh();
    chk("bounce_level_rise", 32'(button_level), 1);
    step(1);
    chk("bounce_state", 32'(state), 2);
    dlow();
    chk("bounce_one_advance", 32'(sc_cnt - sc_base), 1);
    button = 1'b0;
    step(3);
    dpulse(4);
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    auto_en = 1'b1;
    step(2);
    sc_base = sc_cnt;
    for (int i = 0; i < 5; i++) begin
      spulse();
      chk($sformatf("auto_state_%0d", i), 32'(state), 32'(exp_seq[i]));
      chk($sformatf("auto_first_pass_%0d", i), 32'(first_pass), 0);
      sfinish();
    end
    chk("auto_change_count", 32'(sc_cnt - sc_base), 5);
    auto_en = 1'b0;
    spulse();
    sfinish();
    chk("auto_disabled_hold", 32'(state), 1);
    auto_en = 1'b1;
    sc_base = sc_cnt;
    button = 1'b1;
    step(3);
    dpulse(3);
    dhigh();
    slow_tick = 1'b1;
    step(1);
    chk("coinc_state", 32'(state), 2);
    chk("coinc_change", 32'(state_change), 1);
    step(1);
    chk("coinc_change_single", 32'(state_change), 0);
    auto_en = 1'b0;
    step(1);
    debounce_tick = 1'b0;
    step(4);
    chk("coinc_one_advance", 32'(sc_cnt - sc_base), 1);
    chk("coinc_state_hold", 32'(state), 2);
    slow_tick = 1'b0;
    button = 1'b0;
    step(3);
    dpulse(4);
    button = 1'b1;
    step(3);
    dpulse(2);
    chk("mid_state_before_rst", 32'(state), 2);
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    chk("mid_rst_state", 32'(state), 0);
    chk("mid_rst_first_pass", 32'(first_pass), 1);
    chk("mid_rst_level", 32'(button_level), 0);
    step(3);
    dpulse(3);
    chk("mid_rst_full_debounce", 32'(button_level), 0);
    dhigh();
    chk("mid_rst_level_rise", 32'(button_level), 1);
    step(1);
    chk("mid_rst_advance", 32'(state), 1);
    chk("mid_rst_first_pass_clear", 32'(first_pass), 0);
    dlow();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
